// File: rtl/reg_bank_pkg.sv
// Shared types and sizing for the 32x8 register bank and its clear sequencer.
// Widths are fixed by the downstream 32-to-1 8-bit read multiplexer.
package reg_bank_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/reg_bank_32x8_if.sv
// Write port, bulk-clear handshake and flattened read bus of the register bank.
// The master side is the bank's user; the slave side is the bank itself.
interface reg_bank_32x8_if;
    import reg_bank_pkg::*;

    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic                    wr_ready;
    logic                    clr_req;
    logic                    busy;
    logic                    clr_done;
    logic [DEPTH*DATA_W-1:0] q_flat;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output clr_req,
        input  wr_ready,
        input  busy,
        input  clr_done,
        input  q_flat
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  clr_req,
        output wr_ready,
        output busy,
        output clr_done,
        output q_flat
    );

endinterface

// File: rtl/reg_bank_32x8_clr_seq_ctrl.sv
// Bulk-clear sequencer: IDLE/CLEAR/DONE FSM plus the sweep index counter.
// All handshake outputs decode from registered state, so they are glitch-free.
module clr_seq_ctrl
    import reg_bank_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req_i,
    output logic [ADDR_W-1:0] idx_o,
    output logic              clr_en_o,
    output logic              busy_o,
    output logic              clr_done_o,
    output logic              wr_ready_o
);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    // NOTE: sequential state uses non-blocking assignments only; blocking here
    // would let later readers in the same time step see the updated value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: every output gets a default before the case, so no path can leave
    // a signal unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        clr_en_o   = 1'b0;
        busy_o     = 1'b0;
        clr_done_o = 1'b0;
        wr_ready_o = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (clr_req_i) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                wr_ready_o = 1'b0;
                busy_o     = 1'b1;
                clr_en_o   = 1'b1;
                idx_d      = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                clr_done_o = 1'b1;
                if (clr_req_i) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign idx_o = idx_q;

endmodule

// File: rtl/reg_bank_32x8.sv
// 32x8 register bank with one synchronous write port and a 32-cycle bulk clear.
// q_flat feeds the 32-to-1 read mux directly; lane i is register i.
module reg_bank_32x8
    import reg_bank_pkg::*;
#(
    parameter bit ZERO_REG = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    reg_bank_32x8_if.slave  bus
);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    logic [ADDR_W-1:0] clr_idx;
    logic              clr_en;
    logic              wr_ready;
    logic              wr_fire;

    clr_seq_ctrl u_clr_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req_i  (bus.clr_req),
        .idx_o      (clr_idx),
        .clr_en_o   (clr_en),
        .busy_o     (bus.busy),
        .clr_done_o (bus.clr_done),
        .wr_ready_o (wr_ready)
    );

    assign bus.wr_ready = wr_ready;
    assign wr_fire      = bus.wr_en && wr_ready;

    // Writes are never accepted during CLEAR, so write and sweep never collide.
    always_comb begin
        regs_d = regs_q;
        if (wr_fire) begin
            regs_d[bus.wr_addr] = bus.wr_data;
        end
        if (clr_en) begin
            regs_d[clr_idx] = '0;
        end
        if (ZERO_REG) begin
            regs_d[0] = '0;
        end
    end

    // NOTE: the storage is flops, not a RAM macro, so it can and must be
    // reset; the mux downstream must never see X after the first reset edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_lane
        if (ZERO_REG && (i == 0)) begin : g_zero
            assign bus.q_flat[i*DATA_W +: DATA_W] = '0;
        end else begin : g_reg
            assign bus.q_flat[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

    // Handshake invariants the mux-side user relies on.
    a_busy_excl_ready : assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.busy && bus.wr_ready));
    a_done_one_cycle : assert property (@(posedge clk) disable iff (!rst_n)
        bus.clr_done |=> !bus.clr_done);

endmodule

// File: tb/tb_reg_bank_32x8.sv
// Scoreboard bench for reg_bank_32x8: directed plan then random traffic,
// checked against a countdown-based behavioural model of the bank.
module tb_reg_bank_32x8;
    import reg_bank_pkg::*;

    typedef struct {
        logic [DEPTH*DATA_W-1:0] q;
        logic                    busy;
        logic                    done;
        logic                    rdy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reg_bank_32x8_if bus ();

    reg_bank_32x8 #(.ZERO_REG(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model: plain array plus "sweep cycles remaining" counter.
    logic [7:0] model [32];
    int         sweep_left;
    bit         done_flag;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, predict the post-edge outputs, advance one edge.
    task automatic step(input bit rst, input bit we, input logic [4:0] addr,
                        input logic [7:0] data, input bit clr);
        exp_t e;
        bit   accept;
        rst_n       = !rst;
        bus.wr_en   = we;
        bus.wr_addr = addr;
        bus.wr_data = data;
        bus.clr_req = clr;

        if (rst) begin
            foreach (model[i]) model[i] = 8'h00;
            sweep_left = 0;
            done_flag  = 1'b0;
        end else begin
            accept = (sweep_left == 0);
            if (we && accept && addr != 5'd0) model[addr] = data;
            if (sweep_left > 0) begin
                model[32 - sweep_left] = 8'h00;
                sweep_left--;
                done_flag = (sweep_left == 0);
            end else begin
                done_flag = 1'b0;
                if (clr) sweep_left = 32;
            end
        end

        for (int i = 0; i < 32; i++) e.q[i*8 +: 8] = model[i];
        e.busy = (sweep_left > 0);
        e.done = done_flag;
        e.rdy  = (sweep_left == 0);
        exp_q.push_back(e);

        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    endtask

    // Monitor: compares DUT outputs on the falling edge against queued predictions.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("q_flat",   bus.q_flat,   mon_e.q);
                check("busy",     256'(bus.busy),     256'(mon_e.busy));
                check("clr_done", 256'(bus.clr_done), 256'(mon_e.done));
                check("wr_ready", 256'(bus.wr_ready), 256'(mon_e.rdy));
            end
        end
    end

    initial begin
        // 1. Reset for two edges.
        step(1'b1, 1'b0, 5'd0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 5'd0, 8'h00, 1'b0);
        idle(2);

        // 2. Write/read.
        step(1'b0, 1'b1, 5'd7,  8'hA5, 1'b0);
        step(1'b0, 1'b1, 5'd31, 8'h3C, 1'b0);
        idle(2);

        // 3. Preload all with FF, then bulk clear.
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 5'(i), 8'hFF, 1'b0);
        step(1'b0, 1'b0, 5'd0, 8'h00, 1'b1);
        idle(35);

        // 4. Write held through CLEAR; commits at the DONE edge.
        step(1'b0, 1'b0, 5'd0, 8'h00, 1'b1);
        for (int i = 0; i < 33; i++) step(1'b0, 1'b1, 5'd5, 8'h11, 1'b0);
        idle(2);

        // 5. Write + clear collision, then zero register write.
        step(1'b0, 1'b1, 5'd3, 8'h77, 1'b1);
        idle(34);
        step(1'b0, 1'b1, 5'd0, 8'hEE, 1'b0);
        idle(2);

        // 6. Reset at sweep cycle 10.
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 5'(i), 8'h5A, 1'b0);
        step(1'b0, 1'b0, 5'd0, 8'h00, 1'b1);
        idle(10);
        step(1'b1, 1'b0, 5'd0, 8'h00, 1'b0);
        idle(40);

        // Random traffic with occasional clears and rare resets.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(299) == 0,
                 $urandom_range(1) == 1,
                 5'($urandom_range(31)),
                 8'($urandom_range(255)),
                 $urandom_range(39) == 0);
        end
        idle(3);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d exp 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
